// File: rtl/simd_col_sequencer.sv
// Purpose: runs one 128-bit vector op through the 32-bit column ALU, one column per cycle.
// Latency: 5 cycles from the accept edge to out_valid; minimum issue interval is 6 cycles.
// Backpressure: in_ready is high only in IDLE; out_ready low holds DONE with out_data stable.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operation handshake (op_a, op_b, op_sel, op_bcast)
//   alu_a/alu_b/alu_select      column operands to the combinational ALU
//   alu_result                  column result returned by the ALU
//   out_valid/out_ready         result handshake, out_data holds the 128-bit result
module simd_col_sequencer #(
    parameter int COLS = 4,
    parameter int WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COLS*WORD-1:0] op_a,
    input  logic [COLS*WORD-1:0] op_b,
    input  logic [2:0]           op_sel,
    input  logic                 op_bcast,
    output logic [WORD-1:0]      alu_a,
    output logic [WORD-1:0]      alu_b,
    output logic [2:0]           alu_select,
    input  logic [WORD-1:0]      alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*WORD-1:0] out_data
);

    localparam int VW = COLS * WORD;
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [VW-1:0]   a_q, a_d;
    logic [VW-1:0]   b_q, b_d;
    logic [2:0]      sel_q, sel_d;
    logic            bc_q, bc_d;
    logic [VW-1:0]   res_q, res_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            bc_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            bc_q    <= bc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        bc_d       = bc_q;
        res_d      = res_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_select = '0;
        out_data   = res_q;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sel_d   = op_sel;
                    bc_d    = op_bcast;
                    col_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_select = sel_q;
                // Column mux: the ALU sees one slice per cycle and its
                // combinational result lands in the matching result slice.
                for (int k = 0; k < COLS; k++) begin
                    if (col_q == CW'(k)) begin
                        alu_a = a_q[k*WORD +: WORD];
                        // Broadcast reuses column 0 of B (e.g. a rotate amount).
                        alu_b = bc_q ? b_q[WORD-1:0] : b_q[k*WORD +: WORD];
                        res_d[k*WORD +: WORD] = alu_result;
                    end
                end
                if (col_q == CW'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simd_col_sequencer.sv
module tb_simd_col_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic [2:0]   op_sel;
    logic         op_bcast;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [2:0]   alu_select;
    logic [31:0]  alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int tests = 0;
    int fails = 0;

    simd_col_sequencer #(.COLS(4), .WORD(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .op_bcast   (op_bcast),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- column ALU reference ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 of the AES column is the most significant byte.
    function automatic logic [31:0] alu_ref(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [7:0] s0, s1, s2, s3;
        logic [31:0] r;
        s0 = a[31:24]; s1 = a[23:16]; s2 = a[15:8]; s3 = a[7:0];
        r = a;
        case (s)
            3'b101: begin
                r[31:24] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
                r[23:16] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
                r[15:8]  = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
                r[7:0]   = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
            end
            3'b100: begin
                case (b[1:0])
                    2'd0: r = a;
                    2'd1: r = {a[23:0], a[31:24]};
                    2'd2: r = {a[15:0], a[31:16]};
                    default: r = {a[7:0], a[31:8]};
                endcase
            end
            3'b000: for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
            3'b001: for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
            3'b010: r = a ^ b;
            3'b011: r = a & b;
            default: r = a;
        endcase
        alu_ref = r;
    endfunction

    assign alu_result = alu_ref(alu_select, alu_a, alu_b);

    // Whole-vector result: the ALU applied independently to each column.
    function automatic logic [127:0] vec_ref(input logic [127:0] a, input logic [127:0] b,
                                             input logic [2:0] s, input logic bc);
        logic [127:0] r;
        logic [31:0] bk;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            bk = bc ? b[31:0] : b[k*32 +: 32];
            r[k*32 +: 32] = alu_ref(s, a[k*32 +: 32], bk);
        end
        vec_ref = r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level timeline model ----------------
    // m_age counts cycles since the accept: 1..4 are the column cycles,
    // 5 means the result is on offer until the consumer takes it.
    int           m_age = 0;
    logic [127:0] m_a = '0, m_b = '0, m_exp = '0;
    logic [2:0]   m_sel = '0;
    logic         m_bc = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age <= 0;
        end else if (m_age == 0) begin
            if (in_valid) begin
                m_a   <= op_a;
                m_b   <= op_b;
                m_sel <= op_sel;
                m_bc  <= op_bcast;
                m_exp <= vec_ref(op_a, op_b, op_sel, op_bcast);
                m_age <= 1;
            end
        end else if (m_age < 5) begin
            m_age <= m_age + 1;
        end else if (out_ready) begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] ea, eb;
        logic [2:0]  es;
        int k;
        ea = '0; eb = '0; es = '0;
        chk("in_ready", 128'(in_ready), 128'(m_age == 0));
        chk("out_valid", 128'(out_valid), 128'(m_age == 5));
        if (m_age == 5) chk("out_data", out_data, m_exp);
        if (m_age >= 1 && m_age <= 4) begin
            k  = m_age - 1;
            ea = m_a[k*32 +: 32];
            eb = m_bc ? m_b[31:0] : m_b[k*32 +: 32];
            es = m_sel;
        end
        chk("alu_a", 128'(alu_a), 128'(ea));
        chk("alu_b", 128'(alu_b), 128'(eb));
        chk("alu_select", 128'(alu_select), 128'(es));
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] cap_b [4];

    task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic [2:0] s,
                         input logic bc, output logic [127:0] res, output int lat);
        @(posedge clk); #1;
        op_a = a; op_b = b; op_sel = s; op_bcast = bc; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs so a design that fails to latch is exposed.
        in_valid = 1'b0; op_a = ~a; op_b = ~b; op_sel = ~s; op_bcast = ~bc;
        lat = 0;
        res = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n <= 4) cap_b[n-1] = alu_b;
            if (out_valid) begin
                lat = n;
                res = out_data;
                break;
            end
        end
        if (lat == 0) chk("op_timeout", 128'(out_valid), 128'(1));
    endtask

    logic [127:0] res, hold, ra, rb;
    int lat;
    logic [2:0] sels [6];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0;
        op_bcast = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_alu_a", 128'(alu_a), 128'(0));
        chk("rst_alu_b", 128'(alu_b), 128'(0));
        chk("rst_alu_sel", 128'(alu_select), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        chk("idle_out_valid", 128'(out_valid), 128'(0));

        // GF mix on a known AES MixColumns vector
        do_op({4{32'hdb135345}}, 128'h0, 3'b101, 1'b0, res, lat);
        chk("gf_data", res, {4{32'h8e4da1bc}});
        chk("gf_latency", 128'(lat), 128'(5));

        // Byte rotate by one, amount broadcast from B column 0
        do_op(128'h00112233_44556677_8899aabb_ccddeeff, 128'h1, 3'b100, 1'b1, res, lat);
        chk("rot_bc_data", res, 128'h11223300_55667744_99aabb88_ddeeffcc);
        chk("rot_bc_latency", 128'(lat), 128'(5));

        // Per-column rotate amounts 0,1,2,3
        do_op(128'h00112233_44556677_8899aabb_ccddeeff, {32'd3, 32'd2, 32'd1, 32'd0},
              3'b100, 1'b0, res, lat);
        chk("rot_col_data", res, 128'h33001122_66774455_99aabb88_ccddeeff);
        for (int k = 0; k < 4; k++) chk("rot_col_alu_b", 128'(cap_b[k]), 128'(k));

        // Backpressure: hold the result for 10 cycles while new ops knock
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op({4{32'h01020304}}, {4{32'h10203040}}, 3'b000, 1'b0, hold, lat);
        chk("bp_data", hold, {4{32'h11223344}});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op_a = {4{$urandom}}; op_sel = 3'b010;
            @(negedge clk);
            chk("bp_hold_data", out_data, hold);
            chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
            chk("bp_hold_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        do_op({4{32'hff00ff00}}, {4{32'h0f0f0f0f}}, 3'b011, 1'b0, res, lat);
        chk("bp_second_data", res, {4{32'h0f000f00}});
        chk("bp_second_latency", 128'(lat), 128'(5));

        // Reset in the middle of RUN aborts the op
        @(posedge clk); #1;
        op_a = {4{32'hdeadbeef}}; op_b = '0; op_sel = 3'b101; op_bcast = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, 128'(0));
        chk("mid_rst_alu_a", 128'(alu_a), 128'(0));
        chk("mid_rst_alu_sel", 128'(alu_select), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_no_pulse", 128'(out_valid), 128'(0));
        end

        // Byte-lane and pass-through selects with random operands
        sels[0] = 3'b000; sels[1] = 3'b001; sels[2] = 3'b010;
        sels[3] = 3'b011; sels[4] = 3'b110; sels[5] = 3'b111;
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            do_op(ra, rb, sels[i], 1'(i >= 4), res, lat);
            chk("lane_data", res, vec_ref(ra, rb, sels[i], 1'(i >= 4)));
            chk("lane_latency", 128'(lat), 128'(5));
        end

        @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simd_col_sequencer.md
# simd_col_sequencer

Multi-cycle sequencer that wraps the 32-bit column ALU (`Multi_Alu`) and makes it process a full 128-bit AES state. It accepts one 128-bit vector operation through a valid/ready handshake. It then feeds the ALU one 32-bit column per cycle over four cycles, captures each combinational column result, and returns the reassembled 128-bit result through a second valid/ready handshake. It sits between the vector register read/issue logic (upstream) and the `Multi_Alu` datapath (downstream).

## Interface

Parameters:
- `COLS`, 4: columns per vector. Fixed at 4; the counter is 2 bits.
- `WORD`, 32: column width in bits. Must match the ALU.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: an operation is presented on `op_a`, `op_b`, `op_sel`, `op_bcast`.
- `in_ready`, out, 1: sequencer can accept an operation (high only in IDLE).
- `op_a`, in, 128: operand A; column k = `op_a[32k+31:32k]`.
- `op_b`, in, 128: operand B; column k = `op_b[32k+31:32k]`.
- `op_sel`, in, 3: ALU select, forwarded unchanged (`3'b101` = GF mix, `3'b100` = byte rotate, others = byte-lane ALU).
- `op_bcast`, in, 1: 1 = drive `op_b[31:0]` as B for every column (rotate amount broadcast).
- `alu_a`, out, 32: column A operand to the ALU.
- `alu_b`, out, 32: column B operand to the ALU.
- `alu_select`, out, 3: select to the ALU.
- `alu_result`, in, 32: combinational column result from the ALU.
- `out_valid`, out, 1: `out_data` holds a completed result.
- `out_ready`, in, 1: consumer accepts `out_data`.
- `out_data`, out, 128: reassembled result; column k in bits `[32k+31:32k]`.

## Operation

- Operands are latched on accept into internal registers `a_q[127:0]`, `b_q[127:0]`, `sel_q[2:0]`, `bc_q`. Upstream may change its inputs after the accept edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid`=1, latch the operands, set `col`=0, clear `res_q`, and go to RUN.
  - RUN: each cycle drive:
    - `alu_a`=`a_q[32col+:32]`
    - `alu_b`=`bc_q ? b_q[31:0] : b_q[32col+:32]`
    - `alu_select`=`sel_q`
  - RUN, at the clock edge: write `res_q[32col+:32]`←`alu_result` and increment `col`. When `col`=3, go to DONE instead.
  - DONE: `out_valid`=1 and `out_data`=`res_q`, both held stable until `out_valid&&out_ready`; then go to IDLE.
- `in_valid` is ignored outside IDLE. There is no accept in the same cycle as the DONE handshake; the next accept happens earliest in the following IDLE cycle.
- In IDLE and DONE, `alu_a`, `alu_b` and `alu_select` are driven to 0.
- `op_sel` codes are not checked. Every code is forwarded to the ALU, and whatever the ALU returns is stored.
- The column index wraps only through the state change at `col`=3; it never re-enters RUN from 0 without a new accept.

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE, `col`=0, all operand and result registers=0.
- Output values while in reset:
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0
  - `alu_a`=`alu_b`=0
  - `alu_select`=0
- Reset asserted mid-RUN or mid-DONE aborts the operation. The partial result is discarded and never presented.
- Accept at edge T0 (`in_valid&&in_ready`):
  - RUN columns 0..3 occupy cycles T0+1..T0+4.
  - `out_valid` rises after edge T0+4, so it is visible in cycle T0+5.
- Latency is 5 cycles from the accept edge to `out_valid`. Minimum issue interval is 6 cycles with `out_ready` held at 1.
- `out_ready` held 0 keeps the FSM in DONE indefinitely with `out_data` unchanged.
- All outputs are registered or decoded from registered state. The only combinational path is `alu_result` → `res_q` D-input.

## Test plan

- Reset, then idle: `in_ready`=1, `out_valid`=0, `out_data`=0, ALU outputs 0. Assert `rst_n`=0 mid-RUN → next cycle IDLE, `out_valid` never pulses.
- GF mix: `op_sel`=101, `op_a`={4{32'hdb135345}} → `out_data`={4{32'h8e4da1bc}}, `out_valid` 5 cycles after accept.
- Rotate with broadcast: `op_sel`=100, `op_bcast`=1, `op_b`=128'h1, `op_a`=128'h00112233_44556677_8899aabb_ccddeeff → `out_data`=128'h11223300_55667744_99aabb88_ddeeffcc.
- Per-column B with `op_bcast`=0, `op_sel`=100, B columns 0,1,2,3 = 0,1,2,3: check `alu_b` equals the column-k slice in RUN cycle k, and `out_data` column k is rotated by k bytes.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stable, `in_ready`=0, new `in_valid` ignored. Release → IDLE next cycle, then a second op completes correctly.
- Byte-lane select 000..011 with random operands: `out_data` matches the ALU reference model applied per column, with column order preserved (column 0 = bits [31:0]).
